// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad one column at a time.
// It debounces whole-scan results and emits one registered key event per press.
// Optional feature: define KEYPAD_ASCII_EN to make key_code the ASCII legend
// character. Without it, key_code is {4'h0, index}.
// Event interface: key_valid is a one-cycle strobe with no backpressure.
// key_code is valid in that cycle and holds until the next strobe.
// key_held is high while the accepted key stays debounced-pressed.
module keypad_scanner #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [7:0] key_code,
    output logic       key_valid,
    output logic       key_held
);
    localparam int              DW         = $clog2(SCAN_DIV);
    localparam logic [DW-1:0]   DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [7:0]      STABLE_CNT = 8'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {RES_NONE = 2'd0, RES_KEY = 2'd1, RES_MULTI = 2'd2} res_kind_t;
    typedef struct packed {
        res_kind_t  kind;
        logic [3:0] idx;
    } scan_res_t;
    typedef enum logic {RELEASED = 1'b0, PRESSED = 1'b1} state_t;

    logic [3:0]    row_s1, row_s2;
    logic [DW-1:0] dwell;
    logic [1:0]    col_idx;
    logic          sample_edge, scan_done, eval;
    logic [15:0]   hits, hits_full;
    logic [4:0]    hit_count;
    logic [3:0]    hit_idx;
    scan_res_t     new_res, prev_res;
    logic [7:0]    stab_cnt;
    logic          stable;
    state_t        state, state_next;
    logic          fire;

    // Map a key index to its output code (ASCII legend or raw index).
    function automatic logic [7:0] code_of(input logic [3:0] idx);
`ifdef KEYPAD_ASCII_EN
        case (idx)
            4'd0:    code_of = 8'h31;
            4'd1:    code_of = 8'h32;
            4'd2:    code_of = 8'h33;
            4'd3:    code_of = 8'h41;
            4'd4:    code_of = 8'h34;
            4'd5:    code_of = 8'h35;
            4'd6:    code_of = 8'h36;
            4'd7:    code_of = 8'h42;
            4'd8:    code_of = 8'h37;
            4'd9:    code_of = 8'h38;
            4'd10:   code_of = 8'h39;
            4'd11:   code_of = 8'h43;
            4'd12:   code_of = 8'h2A;
            4'd13:   code_of = 8'h30;
            4'd14:   code_of = 8'h23;
            default: code_of = 8'h44;
        endcase
`else
        code_of = {4'h0, idx};
`endif
    endfunction

    // Two-flop synchronizer for the asynchronous row inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_s1 <= 4'hF;
            row_s2 <= 4'hF;
        end else begin
            row_s1 <= row_in;
            row_s2 <= row_s1;
        end
    end

    assign sample_edge = (dwell == DWELL_LAST);
    assign scan_done   = sample_edge && (col_idx == 2'd3);

    // Dwell counter and column index; the column advances after its sample edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwell   <= '0;
            col_idx <= 2'd0;
        end else if (sample_edge) begin
            dwell   <= '0;
            col_idx <= col_idx + 2'd1;
        end else begin
            dwell   <= dwell + 1'b1;
        end
    end

    // Active-low one-hot column drive decoded from the column index.
    always_comb begin
        case (col_idx)
            2'd0:    col_out = 4'b1110;
            2'd1:    col_out = 4'b1101;
            2'd2:    col_out = 4'b1011;
            default: col_out = 4'b0111;
        endcase
    end

    // Intersection map with the current column's rows merged in.
    // Bit 4*row+col is set when that key reads closed.
    always_comb begin
        hits_full = hits;
        for (int r = 0; r < 4; r++) begin
            hits_full[{r[1:0], col_idx}] = ~row_s2[r];
        end
    end

    // Latch each column's rows into the intersection map on its sample edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) hits <= '0;
        else if (sample_edge) hits <= hits_full;
    end

    // Classify the full scan as NONE, a single KEY, or MULTI.
    always_comb begin
        hit_count = 5'd0;
        hit_idx   = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (hits_full[i]) begin
                hit_count = hit_count + 5'd1;
                hit_idx   = 4'(i);
            end
        end
        new_res = '{kind: RES_NONE, idx: 4'h0};
        if (hit_count == 5'd1)     new_res = '{kind: RES_KEY, idx: hit_idx};
        else if (hit_count > 5'd1) new_res = '{kind: RES_MULTI, idx: 4'h0};
    end

    assign stable = (stab_cnt == STABLE_CNT);

    // Register the scan result and its saturating run-length on the column-3 sample edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_res <= '{kind: RES_NONE, idx: 4'h0};
            stab_cnt <= 8'd0;
            eval     <= 1'b0;
        end else begin
            eval <= scan_done;
            if (scan_done) begin
                if (new_res != prev_res) begin
                    prev_res <= new_res;
                    stab_cnt <= 8'd1;
                end else if (stab_cnt != STABLE_CNT) begin
                    stab_cnt <= stab_cnt + 8'd1;
                end
            end
        end
    end

    // Debounce FSM state register and the registered event outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RELEASED;
            key_valid <= 1'b0;
            key_code  <= 8'h00;
        end else begin
            state     <= state_next;
            key_valid <= fire;
            if (fire) key_code <= code_of(prev_res.idx);
        end
    end

    // Next state: a press is accepted only from RELEASED, and only a stable NONE releases.
    always_comb begin
        state_next = state;
        fire       = 1'b0;
        if (eval && stable) begin
            case (state)
                RELEASED: if (prev_res.kind == RES_KEY) begin
                    state_next = PRESSED;
                    fire       = 1'b1;
                end
                PRESSED: if (prev_res.kind == RES_NONE) state_next = RELEASED;
                default: state_next = RELEASED;
            endcase
        end
    end

    assign key_held = (state == PRESSED);

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with SCAN_DIV=8 and DEBOUNCE_SCANS=3.
// It uses a switch-matrix keypad model and a scoreboard of expected events.
// Each queue entry is {expected cycle, expected code}.
module tb_keypad_scanner;
    localparam int SCAN_DIV = 8;
    localparam int DEB      = 3;
    localparam int SCAN     = 4 * SCAN_DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [7:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] key_mat = '0;
    int          cyc;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [39:0] exp_q[$];

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
        .clk       (clk),
        .rst       (rst),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    // Clock and cycle counter (cycles since reset release).
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Keypad model: a row reads low when a closed key sits in the driven column.
    always_comb begin
        row_in[0] = ~|(key_mat[3:0]   & ~col_out);
        row_in[1] = ~|(key_mat[7:4]   & ~col_out);
        row_in[2] = ~|(key_mat[11:8]  & ~col_out);
        row_in[3] = ~|(key_mat[15:12] & ~col_out);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_code(input int idx);
`ifdef KEYPAD_ASCII_EN
        string legend;
        legend = "123A456B789C*0#D";
        return legend[idx];
`else
        return 8'(idx);
`endif
    endfunction

    task automatic expect_pulse(input int idx, input int at_cyc);
        exp_q.push_back({at_cyc[31:0], exp_code(idx)});
    endtask

    task automatic scans(input int n);
        repeat (n * SCAN) @(negedge clk);
    endtask

    // Scoreboard: every key_valid cycle must match the head of the expected queue.
    always @(negedge clk) begin
        logic [39:0] e;
        if (!rst && key_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("event_code", key_code, e[7:0]);
                check("event_cycle", cyc, e[39:8]);
            end
        end
    end

    initial begin
        logic [3:0] exp_col;
        int         t;

        // Reset state.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_col_out", col_out, 4'b1110);
        check("rst_key_code", key_code, 8'h00);
        check("rst_key_valid", key_valid, 1'b0);
        check("rst_key_held", key_held, 1'b0);
        rst = 1'b0;

        // 1: idle column scan, 8 cycles per column.
        for (int n = 0; n < SCAN; n++) begin
            exp_col = ~(4'b0001 << (n / SCAN_DIV));
            check("idle_col_out", col_out, exp_col);
            @(negedge clk);
        end
        check("idle_key_code", key_code, 8'h00);

        // 2: close (1,1) for 6 scans, then release.
        key_mat[5] = 1'b1;
        expect_pulse(5, cyc + DEB * SCAN + 1);
        scans(6);
        check("t2_pending", exp_q.size(), 0);
        check("t2_held", key_held, 1'b1);
        check("t2_code", key_code, exp_code(5));
        key_mat[5] = 1'b0;
        t = cyc;
        repeat (DEB * SCAN) @(negedge clk);
        check("t2_held_before_release", key_held, 1'b1);
        @(negedge clk);
        check("t2_held_after_release", key_held, 1'b0);
        repeat (SCAN - 1) @(negedge clk);
        check("t2_realign", cyc - t, SCAN * (DEB + 1));

        // 3: toggle (0,3) every scan for 4 scans, then hold 5 scans.
        for (int s = 0; s < 4; s++) begin
            key_mat[3] = (s % 2 == 0);
            scans(1);
        end
        key_mat[3] = 1'b1;
        expect_pulse(3, cyc + DEB * SCAN + 1);
        scans(5);
        check("t3_pending", exp_q.size(), 0);
        check("t3_code", key_code, exp_code(3));
        key_mat[3] = 1'b0;
        scans(4);
        check("t3_released", key_held, 1'b0);

        // 4: two keys in one column -> MULTI, never accepted.
        key_mat[0] = 1'b1;
        key_mat[4] = 1'b1;
        scans(10);
        check("t4_held", key_held, 1'b0);
        check("t4_code_kept", key_code, exp_code(3));
        key_mat = '0;
        scans(4);

        // 5: hold (3,1), roll to (2,2) without release, then release and press (2,2).
        key_mat[13] = 1'b1;
        expect_pulse(13, cyc + DEB * SCAN + 1);
        scans(4);
        key_mat[10] = 1'b1;
        scans(1);
        key_mat[13] = 1'b0;
        scans(5);
        check("t5_pending", exp_q.size(), 0);
        check("t5_roll_held", key_held, 1'b1);
        check("t5_roll_code", key_code, exp_code(13));
        key_mat = '0;
        scans(4);
        check("t5_released", key_held, 1'b0);
        key_mat[10] = 1'b1;
        expect_pulse(10, cyc + DEB * SCAN + 1);
        scans(4);
        check("t5_second_code", key_code, exp_code(10));
        key_mat = '0;
        scans(4);

        // 6: reset while PRESSED with the key still closed.
        key_mat[5] = 1'b1;
        expect_pulse(5, cyc + DEB * SCAN + 1);
        scans(4);
        check("t6_pending", exp_q.size(), 0);
        check("t6_held", key_held, 1'b1);
        repeat (13) @(negedge clk);
        rst = 1'b1;
        #1;
        check("t6_rst_col_out", col_out, 4'b1110);
        check("t6_rst_key_code", key_code, 8'h00);
        check("t6_rst_key_valid", key_valid, 1'b0);
        check("t6_rst_key_held", key_held, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        expect_pulse(5, DEB * SCAN + 1);
        scans(4);
        check("t6_repeat_pending", exp_q.size(), 0);
        check("t6_repeat_held", key_held, 1'b1);
        key_mat = '0;
        scans(4);
        check("final_held", key_held, 1'b0);
        check("final_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 active-low matrix keypad, debounces it, and emits one registered key event per press. It sits directly upstream of the UART transmitter: `key_valid` drives the transmitter's key-press input, and `key_code` supplies the byte to send. It replaces the fixed transmit code with the actual key pressed. Target clock is 100 MHz.

## Interface
- `SCAN_DIV`, default 100000 — clk cycles each column is driven (1 ms at 100 MHz); legal range ≥ 4.
- `DEBOUNCE_SCANS`, default 10 — consecutive identical full-scan results required to change debounced state; legal range 1–255.
- `clk` input 1 — system clock, rising edge.
- `rst` input 1 — reset, asynchronous, active-high.
- `row_in` input 4 — keypad rows, active-low, externally pulled up, asynchronous to `clk`.
- `col_out` output 4 — column drive, active-low, exactly one bit low at all times.
- `key_code` output 8 — code of the last accepted key; holds until the next accepted key.
- `key_valid` output 1 — one-cycle pulse when a new key is accepted.
- `key_held` output 1 — high while the accepted key is debounced-pressed.

## Operation
- `row_in` passes through a 2-flop synchronizer; both stages reset to 4'hF.
- **Column scan**
  - Dwell counter runs 0..SCAN_DIV-1; column index c runs 0..3 and wraps 3→0.
  - `col_out` = ~(1<<c).
  - Synchronized rows are sampled on the edge where the dwell counter equals SCAN_DIV-1 (the sample edge). The counter then wraps and c advances.
- **Scan result** (formed at the column-3 sample edge from the 4 column samples). It is one of:
  - NONE — no row low in any column.
  - KEY(i) — exactly one row/column intersection low; i = 4*row + col, 0..15.
  - MULTI — two or more intersections low.
- **Stability counter** (8-bit, saturates at DEBOUNCE_SCANS)
  - Result differs from the previous result → counter = 1.
  - Result equals the previous result → counter increments.
  - The result is "stable" once the counter equals DEBOUNCE_SCANS.
- **Debounce FSM**
  - RELEASED, stable KEY(i) → PRESSED. Pulse `key_valid`, load `key_code`, set `key_held`.
  - RELEASED, stable NONE or MULTI → stay in RELEASED.
  - PRESSED, stable NONE → RELEASED; clear `key_held`.
  - PRESSED, stable KEY(j) with j≠i, or stable MULTI → stay in PRESSED. No new event; a release must come first.
  - Holding a key indefinitely produces exactly one `key_valid` pulse. The saturated counter never re-fires.
- **Key legend** (index 0..15): 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D, row-major.
- **Reset values:** `col_out`=4'b1110, `key_code`=8'h00, `key_valid`=0, `key_held`=0, FSM=RELEASED, stability counter=0, previous result=NONE, dwell counter=0, c=0.
- **Reset mid-operation:** everything above returns to its reset value immediately. A key still held after reset deasserts is reported again after DEBOUNCE_SCANS scans; this is intended.

## Timing
- Let S be the column-3 sample edge of the qualifying scan.
  - The scan result and stability counter register on S.
  - The FSM, `key_code`, `key_valid` and `key_held` register on S+1.
  - `key_valid` is high for exactly the cycle following edge S+1.
- Full scan period = 4*SCAN_DIV cycles.
- Press-to-event latency, from the first bounce-free scan: DEBOUNCE_SCANS scans + 1 cycle after S.
- Rows settle for SCAN_DIV-1 cycles before sampling, which covers the 2-cycle synchronizer delay.
- `key_valid` minimum spacing: 2*DEBOUNCE_SCANS scans (a stable release must occur between presses).

## Configuration
- `KEYPAD_ASCII_EN` defined: `key_code` = ASCII of the legend, e.g. '5'=8'h35, 'A'=8'h41, '*'=8'h2A, '#'=8'h23.
- `KEYPAD_ASCII_EN` undefined: `key_code` = {4'h0, i}, e.g. '5'=8'h05, 'D'=8'h0F.
- All timing is identical in both builds.

## Test plan
Bench uses SCAN_DIV=8 and DEBOUNCE_SCANS=3. The keypad model pulls `row_in[r]` low whenever `col_out[c]` is low and key (r,c) is closed.
1. Reset, no keys → `col_out` cycles 1110→1101→1011→0111, 8 cycles each; `key_valid`=0, `key_code`=8'h00.
2. Close (1,1) for 6 scans → exactly one `key_valid` pulse, 1 cycle after the 3rd scan's column-3 sample edge. `key_code`=8'h05 (8'h35 with `KEYPAD_ASCII_EN`); `key_held`=1 until 3 scans after release.
3. Toggle (0,3) every scan for 4 scans, then hold 5 scans → one pulse only, `key_code`=8'h03 (8'h41 ASCII).
4. Close (0,0) and (1,0) together for 10 scans → no pulse, `key_held`=0.
5. Hold (3,1), then roll to (2,2) without release → one pulse with 8'h0D (8'h30) only. Release, then press (2,2) → pulse with 8'h0A (8'h39).
6. Assert `rst` while PRESSED, key still closed → all outputs at reset values within the same cycle. After `rst` deasserts, a new pulse with the same code arrives after 3 scans.
